// File: rtl/ex_vector_lane_if.sv
// Handshake bundle between the ID/EX register, the vector lane unit and the
// EX/MEM register. The slave side is the lane unit; the master side is the
// surrounding pipeline (ID/EX producer and EX/MEM consumer).
interface ex_vector_lane_if #(
  parameter int LANES  = 6,
  parameter int LANE_W = 8
);
  localparam int VW = LANES * LANE_W;

  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [4:0]    alu_control;
  logic [31:0]   rs_scalar;
  logic [VW-1:0] va;
  logic [VW-1:0] vb;
  logic [4:0]    vd_in;
  logic          reg_write_in;
  logic [1:0]    mem_to_reg_in;
  logic          out_valid;
  logic          out_ready;
  logic [VW-1:0] vresult;
  logic [4:0]    vd_out;
  logic          reg_write_out;
  logic [1:0]    mem_to_reg_out;
  logic          illegal_op;
  logic          busy;

  modport master (
    output flush, in_valid, alu_control, rs_scalar, va, vb, vd_in,
           reg_write_in, mem_to_reg_in, out_ready,
    input  in_ready, out_valid, vresult, vd_out, reg_write_out,
           mem_to_reg_out, illegal_op, busy
  );

  modport slave (
    input  flush, in_valid, alu_control, rs_scalar, va, vb, vd_in,
           reg_write_in, mem_to_reg_in, out_ready,
    output in_ready, out_valid, vresult, vd_out, reg_write_out,
           mem_to_reg_out, illegal_op, busy
  );
endinterface

// File: rtl/ex_vector_lane_unit.sv
// Execute-stage vector unit: accepts one decoded vector op, computes one lane
// per cycle into a result accumulator, then holds the result for EX/MEM.
// in_ready is low for the whole operation so the hazard logic stalls ID/EX.
module ex_vector_lane_unit #(
  parameter int LANES  = 6,
  parameter int LANE_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  ex_vector_lane_if.slave  bus
);
  localparam int VW   = LANES * LANE_W;
  localparam int LC_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LC_W-1:0] LAST_LANE = LC_W'(LANES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [LC_W-1:0]     r_lane_cnt;
  logic [4:0]          r_op;
  logic [2:0]          r_shamt;
  logic [VW-1:0]       r_va;
  logic [VW-1:0]       r_vb;
  logic [VW-1:0]       r_vresult;
  logic [4:0]          r_vd;
  logic                r_reg_write;
  logic [1:0]          r_mem_to_reg;
  logic                r_illegal;
  logic                w_accept;
  logic [LANE_W-1:0]   w_a;
  logic [LANE_W-1:0]   w_b;
  logic [LANE_W-1:0]   w_lane;

  function automatic logic [LANE_W-1:0] sat_add_u(input logic [LANE_W-1:0] a,
                                                  input logic [LANE_W-1:0] b);
    logic [LANE_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[LANE_W] ? {LANE_W{1'b1}} : s[LANE_W-1:0];
  endfunction

  function automatic logic [LANE_W-1:0] mul_lo(input logic [LANE_W-1:0] a,
                                               input logic [LANE_W-1:0] b);
    logic [2*LANE_W-1:0] p;
    p = {{LANE_W{1'b0}}, a} * {{LANE_W{1'b0}}, b};
    return p[LANE_W-1:0];
  endfunction

  function automatic logic op_legal(input logic [4:0] op);
    return (op >= 5'h10) && (op <= 5'h18);
  endfunction

  // Unsupported opcodes pass lane A through unchanged.
  function automatic logic [LANE_W-1:0] lane_op(input logic [4:0]        op,
                                                input logic [LANE_W-1:0] a,
                                                input logic [LANE_W-1:0] b,
                                                input logic [2:0]        sh);
    case (op)
      5'h10:   return a + b;
      5'h11:   return a - b;
      5'h12:   return a & b;
      5'h13:   return a | b;
      5'h14:   return a ^ b;
      5'h15:   return mul_lo(a, b);
      5'h16:   return sat_add_u(a, b);
      5'h17:   return a << sh;
      5'h18:   return a >> sh;
      default: return a;
    endcase
  endfunction

  assign w_accept = (r_state == IDLE) && bus.in_valid && !bus.flush;

  // State register; rst aborts any operation immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic; flush outranks every transition.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_accept) w_state_nxt = RUN;
      RUN: begin
        if (bus.flush)                     w_state_nxt = IDLE;
        else if (r_lane_cnt == LAST_LANE)  w_state_nxt = DONE;
      end
      DONE: begin
        if (bus.flush || bus.out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Select the current lane of each operand and compute its result.
  always_comb begin
    w_a = '0;
    w_b = '0;
    for (int k = 0; k < LANES; k++) begin
      if (r_lane_cnt == LC_W'(k)) begin
        w_a = r_va[k*LANE_W +: LANE_W];
        w_b = r_vb[k*LANE_W +: LANE_W];
      end
    end
    w_lane = lane_op(r_op, w_a, w_b, r_shamt);
  end

  // Operand capture at accept; later input changes cannot disturb the op.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_op    <= bus.alu_control;
      r_shamt <= bus.rs_scalar[2:0];
      r_va    <= bus.va;
      r_vb    <= bus.vb;
    end
  end

  // Lane counter, result accumulator and forwarded write-back controls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lane_cnt   <= '0;
      r_vresult    <= '0;
      r_vd         <= '0;
      r_reg_write  <= 1'b0;
      r_mem_to_reg <= '0;
      r_illegal    <= 1'b0;
    end else if (w_accept) begin
      r_lane_cnt   <= '0;
      r_vd         <= bus.vd_in;
      r_reg_write  <= bus.reg_write_in && op_legal(bus.alu_control);
      r_mem_to_reg <= bus.mem_to_reg_in;
      r_illegal    <= !op_legal(bus.alu_control);
    end else if ((r_state != IDLE) && bus.flush) begin
      r_illegal    <= 1'b0;
    end else if (r_state == RUN) begin
      for (int k = 0; k < LANES; k++) begin
        if (r_lane_cnt == LC_W'(k)) r_vresult[k*LANE_W +: LANE_W] <= w_lane;
      end
      r_lane_cnt <= r_lane_cnt + 1'b1;
    end
  end

  assign bus.in_ready       = (r_state == IDLE);
  assign bus.busy           = (r_state != IDLE);
  assign bus.out_valid      = (r_state == DONE);
  assign bus.vresult        = r_vresult;
  assign bus.vd_out         = r_vd;
  assign bus.reg_write_out  = r_reg_write;
  assign bus.mem_to_reg_out = r_mem_to_reg;
  assign bus.illegal_op     = r_illegal;
endmodule

// File: tb/tb_ex_vector_lane_unit.sv
// Bench for ex_vector_lane_unit: directed scenarios plus randomized ops
// compared against a lane-by-lane arithmetic reference model.
module tb_ex_vector_lane_unit;
  localparam int LANES  = 6;
  localparam int LANE_W = 8;
  localparam int VW     = LANES * LANE_W;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  logic [VW-1:0] last_res;

  ex_vector_lane_if #(.LANES(LANES), .LANE_W(LANE_W)) bus ();

  ex_vector_lane_unit #(.LANES(LANES), .LANE_W(LANE_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [VW-1:0] model(input logic [4:0] op, input logic [31:0] sc,
                                          input logic [VW-1:0] va, input logic [VW-1:0] vb);
    logic [VW-1:0] res;
    int a, b, r, sh;
    res = '0;
    sh  = int'(sc % 8);
    for (int k = 0; k < LANES; k++) begin
      a = int'((va >> (k * LANE_W)) % 256);
      b = int'((vb >> (k * LANE_W)) % 256);
      case (op)
        5'h10:   r = (a + b) % 256;
        5'h11:   r = (a - b + 256) % 256;
        5'h12:   r = a & b;
        5'h13:   r = a | b;
        5'h14:   r = a ^ b;
        5'h15:   r = (a * b) % 256;
        5'h16:   r = (a + b > 255) ? 255 : a + b;
        5'h17:   r = (a << sh) % 256;
        5'h18:   r = a >> sh;
        default: r = a;
      endcase
      res = res | (VW'(r) << (k * LANE_W));
    end
    return res;
  endfunction

  task automatic drive_op(input logic [4:0] op, input logic [31:0] sc, input logic [VW-1:0] a,
                          input logic [VW-1:0] b, input logic [4:0] vd, input logic rw,
                          input logic [1:0] m2r);
    bus.alu_control   = op;
    bus.rs_scalar     = sc;
    bus.va            = a;
    bus.vb            = b;
    bus.vd_in         = vd;
    bus.reg_write_in  = rw;
    bus.mem_to_reg_in = m2r;
    bus.in_valid      = 1'b1;
  endtask

  task automatic scramble_inputs();
    bus.in_valid      = 1'b0;
    bus.alu_control   = 5'($urandom);
    bus.rs_scalar     = $urandom;
    bus.va            = VW'({$urandom, $urandom});
    bus.vb            = VW'({$urandom, $urandom});
    bus.vd_in         = 5'($urandom);
    bus.reg_write_in  = 1'($urandom);
    bus.mem_to_reg_in = 2'($urandom);
  endtask

  task automatic do_op(input string tag, input logic [4:0] op, input logic [31:0] sc,
                       input logic [VW-1:0] a, input logic [VW-1:0] b, input logic [4:0] vd,
                       input logic rw, input logic [1:0] m2r, input int hold);
    logic [VW-1:0] exp_res;
    logic          legal;
    int            lat;
    exp_res = model(op, sc, a, b);
    legal   = (op >= 5'h10) && (op <= 5'h18);
    @(negedge clk);
    bus.out_ready = 1'b0;
    drive_op(op, sc, a, b, vd, rw, m2r);
    check({tag, "_in_ready_idle"}, 64'(bus.in_ready), 64'(1));
    @(posedge clk); #1;
    scramble_inputs();
    check({tag, "_busy_after_accept"}, 64'(bus.busy), 64'(1));
    check({tag, "_in_ready_after_accept"}, 64'(bus.in_ready), 64'(0));
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(LANES));
    check({tag, "_vresult"}, 64'(bus.vresult), 64'(exp_res));
    check({tag, "_vd_out"}, 64'(bus.vd_out), 64'(vd));
    check({tag, "_reg_write_out"}, 64'(bus.reg_write_out), 64'(rw && legal));
    check({tag, "_mem_to_reg_out"}, 64'(bus.mem_to_reg_out), 64'(m2r));
    check({tag, "_illegal_op"}, 64'(bus.illegal_op), 64'(!legal));
    last_res = bus.vresult;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, "_hold_out_valid"}, 64'(bus.out_valid), 64'(1));
      check({tag, "_hold_in_ready"}, 64'(bus.in_ready), 64'(0));
      check({tag, "_hold_vresult"}, 64'(bus.vresult), 64'(exp_res));
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check({tag, "_release_in_ready"}, 64'(bus.in_ready), 64'(1));
    check({tag, "_release_out_valid"}, 64'(bus.out_valid), 64'(0));
  endtask

  initial begin
    logic [4:0] rop;
    rst           = 1'b1;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    scramble_inputs();
    #1;
    check("reset_in_ready", 64'(bus.in_ready), 64'(1));
    check("reset_busy", 64'(bus.busy), 64'(0));
    check("reset_out_valid", 64'(bus.out_valid), 64'(0));
    check("reset_vresult", 64'(bus.vresult), 64'(0));
    check("reset_vd_out", 64'(bus.vd_out), 64'(0));
    check("reset_reg_write_out", 64'(bus.reg_write_out), 64'(0));
    check("reset_mem_to_reg_out", 64'(bus.mem_to_reg_out), 64'(0));
    check("reset_illegal_op", 64'(bus.illegal_op), 64'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Flush while idle blocks the accept.
    @(negedge clk);
    drive_op(5'h10, 0, 48'h1, 48'h1, 5'd1, 1'b1, 2'd0);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    check("idle_flush_in_ready", 64'(bus.in_ready), 64'(1));
    check("idle_flush_busy", 64'(bus.busy), 64'(0));
    @(negedge clk);
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;

    do_op("vadd", 5'h10, 32'd0, 48'h0102030405FF, 48'h010101010101, 5'd7, 1'b1, 2'd1, 0);
    check("vadd_literal", 64'(last_res), 64'(48'h020304050600));
    do_op("vsaddu", 5'h16, 32'd0, 48'hF0F0F0F0F0F0, 48'h202020202020, 5'd3, 1'b1, 2'd0, 0);
    check("vsaddu_literal", 64'(last_res), 64'(48'hFFFFFFFFFFFF));
    do_op("vshl", 5'h17, 32'd3, 48'h010203040506, 48'h0, 5'd9, 1'b1, 2'd2, 0);
    check("vshl_literal", 64'(last_res), 64'(48'h081018202830));
    do_op("backpressure", 5'h12, 32'd0, 48'hA5A5F00F1234, 48'h0FF0FFFF00FF, 5'd12, 1'b1, 2'd3, 3);
    do_op("illegal", 5'h03, 32'd0, 48'h123456789ABC, 48'hFFFFFFFFFFFF, 5'd21, 1'b1, 2'd1, 1);
    check("illegal_literal", 64'(last_res), 64'(48'h123456789ABC));

    // Flush after two lanes have been written.
    @(negedge clk);
    drive_op(5'h10, 0, 48'h111111111111, 48'h222222222222, 5'd5, 1'b1, 2'd0);
    @(posedge clk); #1;
    scramble_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    check("flush_run_in_ready", 64'(bus.in_ready), 64'(1));
    check("flush_run_out_valid", 64'(bus.out_valid), 64'(0));
    check("flush_run_illegal", 64'(bus.illegal_op), 64'(0));
    @(negedge clk);
    bus.flush = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      check("flush_run_no_valid", 64'(bus.out_valid), 64'(0));
    end
    do_op("vxor_after_flush", 5'h14, 32'd0, 48'hFFFF00000000, 48'h0F0F0F0F0F0F, 5'd2, 1'b1, 2'd0, 0);
    check("vxor_literal", 64'(last_res), 64'(48'hF0F00F0F0F0F));

    // Asynchronous reset mid-RUN, checked between clock edges.
    @(negedge clk);
    drive_op(5'h15, 0, 48'h030303030303, 48'h050505050505, 5'd30, 1'b1, 2'd3);
    @(posedge clk); #1;
    scramble_inputs();
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("arst_in_ready", 64'(bus.in_ready), 64'(1));
    check("arst_busy", 64'(bus.busy), 64'(0));
    check("arst_out_valid", 64'(bus.out_valid), 64'(0));
    check("arst_vresult", 64'(bus.vresult), 64'(0));
    check("arst_vd_out", 64'(bus.vd_out), 64'(0));
    check("arst_reg_write_out", 64'(bus.reg_write_out), 64'(0));
    check("arst_mem_to_reg_out", 64'(bus.mem_to_reg_out), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    do_op("after_arst", 5'h11, 32'd0, 48'h000102030405, 48'h050403020100, 5'd8, 1'b1, 2'd2, 0);

    for (int n = 0; n < 24; n++) begin
      rop = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(16, 24));
      do_op("random", rop, $urandom, VW'({$urandom, $urandom}), VW'({$urandom, $urandom}),
            5'($urandom), 1'($urandom), 2'($urandom), int'($urandom_range(0, 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
